// File: rtl/ram_64.sv
// 64 x 16-bit RAM: one synchronous write port and a combinational read port
// sharing a single address, organised as eight banks of eight words.
module ram_64 (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] in_i,
    input  logic [5:0]  sel_i,
    input  logic        load_i,
    output logic [15:0] out_o
);

    logic [15:0] mem_q [64];
    logic [2:0]  bank_sel;
    logic [2:0]  word_sel;
    logic [7:0]  bank_load;
    logic [15:0] bank_rd [8];

    assign bank_sel = sel_i[5:3];
    assign word_sel = sel_i[2:0];

    // High address bits steer the write enable to exactly one bank.
    always_comb begin
        bank_load = '0;
        if (load_i) begin
            bank_load[bank_sel] = 1'b1;
        end
    end

    // Reset wins over load, so a write in the reset cycle is dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 64; i++) begin
                mem_q[i] <= 16'h0000;
            end
        end else begin
            for (int b = 0; b < 8; b++) begin
                if (bank_load[b]) begin
                    mem_q[{b[2:0], word_sel}] <= in_i;
                end
            end
        end
    end

    // Each bank presents its addressed word; the high bits pick the bank.
    always_comb begin
        for (int b = 0; b < 8; b++) begin
            bank_rd[b] = mem_q[{b[2:0], word_sel}];
        end
    end

    assign out_o = bank_rd[bank_sel];

endmodule

// File: tb/tb_ram_64.sv
// Directed bench for ram_64: a behavioural memory model feeds a scoreboard
// queue of expected read values, compared against out_o after it settles.
module tb_ram_64;

    logic        clk;
    logic        rst;
    logic [15:0] din;
    logic [5:0]  sel;
    logic        load;
    logic [15:0] dout;

    logic [15:0] model [64];
    logic [15:0] sb_q [$];
    int          n_pass;
    int          n_total;

    ram_64 dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .in_i   (din),
        .sel_i  (sel),
        .load_i (load),
        .out_o  (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge; the model follows the same reset/write rules.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 64; i++) model[i] = 16'h0000;
        end else if (load) begin
            model[sel] = din;
        end
        #1;
    endtask

    task automatic expect_read(input logic [5:0] a);
        sel = a;
        sb_q.push_back(model[a]);
        #1;
    endtask

    task automatic check_out(input string tag);
        logic [15:0] exp;
        n_total++;
        if (sb_q.size() == 0) begin
            $error("FAIL %s: scoreboard empty, observed %h", tag, dout);
        end else begin
            exp = sb_q.pop_front();
            assert (dout === exp) n_pass++;
            else $error("FAIL %s: sel=%0d observed %h expected %h", tag, sel, dout, exp);
        end
    endtask

    task automatic read_check(input logic [5:0] a, input string tag);
        expect_read(a);
        check_out(tag);
    endtask

    task automatic write_word(input logic [5:0] a, input logic [15:0] d);
        sel  = a;
        din  = d;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic check_const(input logic [15:0] exp, input string tag);
        n_total++;
        assert (dout === exp) n_pass++;
        else $error("FAIL %s: sel=%0d observed %h expected %h", tag, sel, dout, exp);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        for (int i = 0; i < 64; i++) model[i] = 16'hxxxx;
        rst  = 1'b1;
        load = 1'b0;
        din  = 16'h0000;
        sel  = 6'd0;
        #2;
        tick();
        rst = 1'b0;

        // Cleared memory reads zero everywhere, with no clock between reads.
        for (int a = 0; a < 64; a++) read_check(6'(a), "reset_sweep");

        write_word(6'd0, 16'hAAAA);
        write_word(6'd1, 16'h1234);
        write_word(6'd2, 16'hDEAD);
        sel = 6'd0; #1; check_const(16'hAAAA, "wr_addr0");
        sel = 6'd1; #1; check_const(16'h1234, "wr_addr1");
        sel = 6'd2; #1; check_const(16'hDEAD, "wr_addr2");
        for (int a = 3; a < 64; a++) read_check(6'(a), "untouched_zero");

        // Hold: load low, in toggled to FFFF, word 1 must not change.
        load = 1'b0;
        din  = 16'hFFFF;
        sel  = 6'd1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_const(16'h1234, "hold_no_load");
        end

        for (int a = 0; a < 64; a++) write_word(6'(a), 16'(a + 1));
        for (int a = 0; a < 64; a++) read_check(6'(a), "fill_readback");
        sel = 6'd63; #1; check_const(16'h0040, "top_addr63");

        // Overwrite: old data visible until the edge, no write-first bypass.
        write_word(6'd5, 16'hBEEF);
        sel  = 6'd5;
        din  = 16'hCAFE;
        load = 1'b1;
        #1;
        check_const(16'hBEEF, "pre_edge_old");
        tick();
        load = 1'b0;
        check_const(16'hCAFE, "last_write_wins");
        read_check(6'd4, "neighbor4");
        read_check(6'd6, "neighbor6");

        // Reset with a simultaneous write request: the write is lost.
        rst  = 1'b1;
        load = 1'b1;
        din  = 16'h5555;
        sel  = 6'd3;
        tick();
        rst  = 1'b0;
        load = 1'b0;
        check_const(16'h0000, "reset_beats_load");
        for (int a = 0; a < 64; a++) read_check(6'(a), "post_reset_sweep");

        n_total++;
        assert (sb_q.size() == 0) n_pass++;
        else $error("FAIL sb_drain: observed %0d leftover expected 0", sb_q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
